// File: rtl/sr_cmd_seq.sv
// sr_cmd_seq: issues fixed-width, non-overlapping set/reset pulses to a
// downstream SR flip-flop. It has a one-deep pending slot for requests that
// arrive while busy, a saturating count of dropped requests, and a sticky
// check of the Q feedback against the expected state.
module sr_cmd_seq #(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 1,
  parameter bit SET_WINS  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req,
  input  logic       clr_req,
  input  logic       q,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       exp_q,
  output logic       mismatch,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [3:0] PLEN_M1 = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GLEN_M1 = 4'(GAP_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cmd_set_q, cmd_set_d;   // polarity of the command in flight
  logic       pend_vld_q, pend_vld_d;
  logic       pend_set_q, pend_set_d;
  logic       s_q, s_d, r_q, r_d;
  logic       exp_q_q, exp_q_d;
  logic       armed_q, armed_d;
  logic       mism_q, mism_d;
  logic [7:0] drop_q, drop_d;

  logic       req_any, req_set, req_both;
  logic       start, start_set;
  logic [1:0] n_drop;
  logic [8:0] drop_sum;

  // Next-state, pending slot, drop accounting and registered drive levels
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_set_d  = cmd_set_q;
    pend_vld_d = pend_vld_q;
    pend_set_d = pend_set_q;
    exp_q_d    = exp_q_q;
    armed_d    = armed_q;
    mism_d     = mism_q;
    start      = 1'b0;
    start_set  = 1'b0;

    req_any  = set_req | clr_req;
    req_both = set_req & clr_req;
    req_set  = set_req & (SET_WINS | ~clr_req);
    // a simultaneous request always loses one of the pair
    n_drop   = {1'b0, req_both};

    case (state_q)
      IDLE: begin
        // an older pending request takes priority; the new one queues behind it
        if (pend_vld_q) begin
          start      = 1'b1;
          start_set  = pend_set_q;
          pend_vld_d = req_any;
          pend_set_d = req_set;
        end else if (req_any) begin
          start     = 1'b1;
          start_set = req_set;
        end
        if (armed_q && (q != exp_q_q)) mism_d = 1'b1;
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          exp_q_d = cmd_set_q;
          armed_d = 1'b1;
          if (GAP_LEN == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GLEN_M1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // while busy the newest request owns the slot; an occupant is dropped
    if (state_q != IDLE && req_any) begin
      if (pend_vld_q) n_drop = n_drop + 2'd1;
      pend_vld_d = 1'b1;
      pend_set_d = req_set;
    end

    if (start) begin
      state_d   = PULSE;
      cnt_d     = PLEN_M1;
      cmd_set_d = start_set;
    end

    // both drives derive from one polarity bit, so they can never overlap
    s_d = (state_d == PULSE) &  cmd_set_d;
    r_d = (state_d == PULSE) & ~cmd_set_d;

    drop_sum = {1'b0, drop_q} + {7'd0, n_drop};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // State register; reset clears everything, including a pulse in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      cmd_set_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_set_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      exp_q_q    <= 1'b0;
      armed_q    <= 1'b0;
      mism_q     <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_set_q  <= cmd_set_d;
      pend_vld_q <= pend_vld_d;
      pend_set_q <= pend_set_d;
      s_q        <= s_d;
      r_q        <= r_d;
      exp_q_q    <= exp_q_d;
      armed_q    <= armed_d;
      mism_q     <= mism_d;
      drop_q     <= drop_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = (state_q != IDLE);
  assign exp_q    = exp_q_q;
  assign mismatch = mism_q;
  assign drop_cnt = drop_q;

endmodule

// File: doc/sr_cmd_seq.md
SR_CMD_SEQ -- requirements
Module: sr_cmd_seq

Interface
REQ-001 Parameter PULSE_LEN, default 2: cycles s or r is held high per command; legal range 1..15.
REQ-002 Parameter GAP_LEN, default 1: minimum cycles of s=r=0 after each pulse; legal range 0..15.
REQ-003 Parameter SET_WINS, default 0: on simultaneous requests, 0 means clear wins and 1 means set wins.
REQ-004 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 set_req  input  1  request to drive the downstream SR flip-flop to Q=1; sampled each rising edge.
REQ-007 clr_req  input  1  request to drive the downstream SR flip-flop to Q=0; sampled each rising edge.
REQ-008 q  input  1  Q feedback from the downstream SR flip-flop.
REQ-009 s  output  1  set drive to the SR flip-flop; registered.
REQ-010 r  output  1  reset drive to the SR flip-flop; registered.
REQ-011 busy  output  1  high while in PULSE or GAP.
REQ-012 exp_q  output  1  expected flip-flop state after the last completed command.
REQ-013 mismatch  output  1  sticky flag, set when checked q differs from exp_q.
REQ-014 drop_cnt  output  8  count of discarded requests; saturates at 255.

Function
REQ-015 s and r SHALL never be high in the same cycle, for any input sequence including reset release.
REQ-016 The FSM SHALL have exactly three states: IDLE, PULSE and GAP.
REQ-017 In IDLE, a valid pending request SHALL be served before any request sampled in the same cycle.
REQ-018 Otherwise, in IDLE, a request sampled at edge k SHALL cause s (set) or r (clear) to be 1 after edges k..k+PULSE_LEN-1, with busy=1 over the same span.
REQ-019 IDLE->PULSE SHALL occur on the sampling edge; PULSE->GAP after PULSE_LEN cycles; GAP->IDLE after GAP_LEN cycles; with GAP_LEN=0, PULSE->IDLE directly.
REQ-020 busy SHALL be 1 throughout PULSE and GAP and 0 in IDLE.
REQ-021 If set_req and clr_req are both high at one edge, one winner SHALL be chosen by SET_WINS, and the loser SHALL be discarded with drop_cnt incremented by 1.
REQ-022 A request arriving while busy SHALL be stored in a one-deep pending slot.
REQ-023 If the pending slot is already full, the newer request SHALL replace it and drop_cnt SHALL increment.
REQ-024 A request sampled in IDLE while a pending request is being served SHALL enter the pending slot, following REQ-023 rules.
REQ-025 exp_q SHALL update on the edge ending the PULSE state: 1 for set, 0 for clear.
REQ-026 A set to an already-set exp_q, or a clear to an already-clear exp_q, SHALL still issue a full pulse.
REQ-027 An internal armed flag SHALL set at the first PULSE completion after reset.
REQ-028 While armed and in IDLE, q != exp_q at any rising edge SHALL set mismatch.
REQ-029 mismatch SHALL hold until reset, and q SHALL be ignored while not armed.
REQ-030 drop_cnt SHALL saturate at 255 and never wrap.
REQ-031 If both a pending overwrite and a simultaneous-request loss occur at one edge, drop_cnt SHALL increment by 2, saturating.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force s=0, r=0, busy=0, exp_q=0, mismatch=0, drop_cnt=0, state=IDLE, pending empty and armed=0, regardless of clk.
REQ-033 Reset asserted mid-PULSE SHALL drop s/r to 0 immediately, with no pulse completion and no exp_q update.
REQ-034 After rst_n rises, requests SHALL be sampled from the first rising edge.

Verification
REQ-035 Directed: defaults, set_req pulsed one cycle at edge 2 -> s=1 after edges 2,3; s=0 after edge 4; exp_q=1 after edge 4; busy low after edge 5.
REQ-036 Directed: set_req=clr_req=1 for one edge in IDLE, SET_WINS=0 -> r pulses, s stays 0, drop_cnt=1; repeat with SET_WINS=1 -> s pulses.
REQ-037 Directed: while busy, clr_req then set_req on successive edges -> drop_cnt increments by 1; after GAP a set pulse issues and no clear pulse issues.
REQ-038 Directed: 300 overwriting requests while busy -> drop_cnt=255 and holds.
REQ-039 Directed: after a completed set with the SR flip-flop model attached, force q=0 in IDLE -> mismatch=1 next edge; mismatch stays 1 after q returns to 1; mismatch=0 only after rst_n pulse.
REQ-040 Directed: rst_n low one cycle into a PULSE -> s=0 immediately, exp_q=0; a request after release -> full PULSE_LEN pulse.
REQ-041 Continuous assertion: s&r==0 every cycle across all scenarios.
